// File: rtl/data_stand_pkg.sv
// data_stand_pkg: shared types and helpers for the data_stand_fifo slice.
// Optional feature macro used by this slice: DATA_STAND_DROPCNT_EN.
package data_stand_pkg;

   // Width of the dropped-capture counter.
   localparam int DROPCNT_W = 16;

   // Occupancy flags derived from the read/write pointers.
   typedef struct packed {
      logic full;
      logic empty;
   } fifo_flags_t;

   // Pointer width: one extra bit above the address so full and empty differ.
   function automatic int ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/data_stand_fifo_strobe_sync_edge.sv
// strobe_sync_edge: brings an asynchronous strobe into the local clock domain
// through a SYNC_STAGES-deep flop chain and emits a registered one-cycle pulse
// on each synchronised rising edge. Reset clears the chain and the edge flop,
// so a strobe held high through reset release yields exactly one pulse.
module strobe_sync_edge #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic async_in,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   prev_q;
   logic                   prev_d;
   logic                   rise_q;
   logic                   rise_d;

   // Next state: shift the strobe in, remember the last synchronised level, detect 0->1.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
      prev_d = sync_q[SYNC_STAGES-1];
      rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
   end

   // Synchroniser, edge-history and pulse registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= {SYNC_STAGES{1'b0}};
         prev_q <= 1'b0;
         rise_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
         rise_q <= rise_d;
      end
   end

   assign rise = rise_q;

endmodule

// File: rtl/data_stand_fifo.sv
// data_stand_fifo: captures data_rec on each synchronised rising edge of the
// asynchronous clock_recovery strobe and queues the words in a DEPTH-entry FIFO
// that drains on a data_valid/data_ready handshake in the clock_50 domain.
// Full-FIFO captures are dropped and flagged on the sticky overflow output.
// Optional: define DATA_STAND_DROPCNT_EN to add the saturating drop_count output.
module data_stand_fifo
   import data_stand_pkg::*;
#(
   parameter int WIDTH       = 14,
   parameter int DEPTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clock_50,
   input  logic                   reset,
   input  logic                   clock_recovery,
   input  logic [WIDTH-1:0]       data_rec,
   output logic [WIDTH-1:0]       data_stand,
   output logic                   data_valid,
   input  logic                   data_ready,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   input  logic                   overflow_clr
`ifdef DATA_STAND_DROPCNT_EN
   ,
   output logic [DROPCNT_W-1:0]   drop_count
`endif
);

   localparam int PTR_W  = ptr_w(DEPTH);
   localparam int ADDR_W = PTR_W - 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [PTR_W-1:0] rd_ptr_d;
   logic [PTR_W-1:0] level_q;
   logic [PTR_W-1:0] level_d;
   logic             data_valid_q;
   logic             data_valid_d;
   logic [WIDTH-1:0] data_stand_q;
   logic [WIDTH-1:0] data_stand_d;
   logic             overflow_q;
   logic             overflow_d;

   fifo_flags_t      flags_s;
   logic             rise_s;
   logic             pop_s;
   logic             push_ok_s;
   logic             drop_s;

   strobe_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_strobe_sync_edge (
      .clk      (clock_50),
      .reset    (reset),
      .async_in (clock_recovery),
      .rise     (rise_s)
   );

   // Full/empty from pointer compare: equal pointers are empty, MSB-only difference is full.
   always_comb begin
      flags_s.empty = (wr_ptr_q == rd_ptr_q);
      flags_s.full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
   end

   // Handshake decode: a pop frees a slot for a same-cycle push even when full.
   always_comb begin
      pop_s     = data_valid_q & data_ready;
      push_ok_s = rise_s & (~flags_s.full | pop_s);
      drop_s    = rise_s & flags_s.full & ~pop_s;
   end

   // Pointer, storage and occupancy next state.
   always_comb begin
      mem_d = mem_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q[ADDR_W-1:0]] = data_rec;
         wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      level_d = wr_ptr_d - rd_ptr_d;
   end

   // Registered head word: the word pushed this cycle shows up only after the edge.
   always_comb begin
      data_valid_d = (level_d != {PTR_W{1'b0}});
      if (data_valid_d) begin
         data_stand_d = mem_d[rd_ptr_d[ADDR_W-1:0]];
      end else begin
         data_stand_d = {WIDTH{1'b0}};
      end
   end

   // Sticky overflow: a new drop takes priority over a clear in the same cycle.
   always_comb begin
      if (drop_s) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // FIFO state registers; reset flushes every queued word.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= {WIDTH{1'b0}};
         end
         wr_ptr_q     <= {PTR_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         level_q      <= {PTR_W{1'b0}};
         data_valid_q <= 1'b0;
         data_stand_q <= {WIDTH{1'b0}};
         overflow_q   <= 1'b0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         data_valid_q <= data_valid_d;
         data_stand_q <= data_stand_d;
         overflow_q   <= overflow_d;
      end
   end

   assign data_stand = data_stand_q;
   assign data_valid = data_valid_q;
   assign level      = level_q;
   assign overflow   = overflow_q;

`ifdef DATA_STAND_DROPCNT_EN
   logic [DROPCNT_W-1:0] drop_count_q;
   logic [DROPCNT_W-1:0] drop_count_d;

   // Drop counter: saturates at all-ones; a drop alongside a clear restarts at one.
   always_comb begin
      if (drop_s) begin
         if (overflow_clr) begin
            drop_count_d = {{(DROPCNT_W-1){1'b0}}, 1'b1};
         end else if (drop_count_q == {DROPCNT_W{1'b1}}) begin
            drop_count_d = drop_count_q;
         end else begin
            drop_count_d = drop_count_q + {{(DROPCNT_W-1){1'b0}}, 1'b1};
         end
      end else if (overflow_clr) begin
         drop_count_d = {DROPCNT_W{1'b0}};
      end else begin
         drop_count_d = drop_count_q;
      end
   end

   // Drop counter register.
   always_ff @(posedge clock_50) begin
      if (reset) begin
         drop_count_q <= {DROPCNT_W{1'b0}};
      end else begin
         drop_count_q <= drop_count_d;
      end
   end

   assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_data_stand_fifo.sv
// tb_data_stand_fifo: directed scenarios plus randomized traffic checked against
// a queue-based reference model of the standardiser FIFO.
module tb_data_stand_fifo;

   localparam int WIDTH = 14;
   localparam int DEPTH = 8;
   localparam int SYNC  = 2;

   logic             clock_50 = 1'b0;
   logic             reset = 1'b1;
   logic             clock_recovery = 1'b0;
   logic [WIDTH-1:0] data_rec = '0;
   logic [WIDTH-1:0] data_stand;
   logic             data_valid;
   logic             data_ready = 1'b0;
   logic [3:0]       level;
   logic             overflow;
   logic             overflow_clr = 1'b0;
`ifdef DATA_STAND_DROPCNT_EN
   logic [15:0]      drop_count;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   logic [WIDTH-1:0] mq[$];
   bit               m_ovf = 1'b0;
   int               m_cnt = 0;
   bit               hist[0:SYNC+1];

   data_stand_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)) dut (
      .clock_50       (clock_50),
      .reset          (reset),
      .clock_recovery (clock_recovery),
      .data_rec       (data_rec),
      .data_stand     (data_stand),
      .data_valid     (data_valid),
      .data_ready     (data_ready),
      .level          (level),
      .overflow       (overflow),
      .overflow_clr   (overflow_clr)
`ifdef DATA_STAND_DROPCNT_EN
      ,
      .drop_count     (drop_count)
`endif
   );

   always #5 clock_50 = ~clock_50;

   function automatic logic [3:0] exp_level();
      return 4'(mq.size());
   endfunction

   function automatic logic [WIDTH-1:0] exp_head();
      if (mq.size() != 0) return mq[0];
      return '0;
   endfunction

   // Advance model by one clock_50 edge using current inputs, then advance the DUT.
   // A capture happens SYNC+1 edges after the strobe was first sampled high.
   task automatic step();
      bit do_push;
      bit do_pop;
      bit drop;
      if (reset) begin
         mq.delete();
         m_ovf = 1'b0;
         m_cnt = 0;
         for (int i = 0; i <= SYNC + 1; i++) hist[i] = 1'b0;
      end else begin
         do_push = hist[SYNC] && !hist[SYNC+1];
         do_pop  = (mq.size() != 0) && data_ready;
         drop    = do_push && (mq.size() == DEPTH) && !do_pop;
         if (do_pop) void'(mq.pop_front());
         if (do_push && !drop) mq.push_back(data_rec);
         if (drop) begin
            m_ovf = 1'b1;
            if (overflow_clr) m_cnt = 1;
            else if (m_cnt < 65535) m_cnt = m_cnt + 1;
         end else if (overflow_clr) begin
            m_ovf = 1'b0;
            m_cnt = 0;
         end
         for (int i = SYNC + 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = clock_recovery;
      end
      @(posedge clock_50);
      #1;
   endtask

   task automatic drain();
      data_ready = 1'b1;
      repeat (DEPTH + 6) step();
      data_ready = 1'b0;
   endtask

   task automatic pulse(input logic [WIDTH-1:0] d);
      data_rec = d;
      clock_recovery = 1'b1;
      step();
      step();
      clock_recovery = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) step();
      n_cmp += 4;
      if (data_stand !== '0) begin n_err++; $display("FAIL reset_data: got %0h expected 0", data_stand); end
      if (data_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b expected 0", data_valid); end
      if (level !== 4'd0) begin n_err++; $display("FAIL reset_level: got %0d expected 0", level); end
      if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
`ifdef DATA_STAND_DROPCNT_EN
      n_cmp++;
      if (drop_count !== 16'd0) begin n_err++; $display("FAIL reset_dropcnt: got %0d expected 0", drop_count); end
`endif
      reset = 1'b0;
      repeat (2) step();
   endtask

   task automatic test_single();
      int lat;
      int words;
      data_ready = 1'b1;
      data_rec = 14'h1A5;
      clock_recovery = 1'b1;
      lat = 0;
      words = 0;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (data_valid === 1'b1) begin
            words++;
            if (lat == 0) begin
               lat = i;
               n_cmp++;
               if (data_stand !== 14'h1A5) begin n_err++; $display("FAIL single_data: got %0h expected 1a5", data_stand); end
            end
         end
      end
      clock_recovery = 1'b0;
      repeat (4) step();
      n_cmp += 3;
      if (lat != SYNC + 2) begin n_err++; $display("FAIL single_latency: got %0d expected %0d", lat, SYNC + 2); end
      if (words != 1) begin n_err++; $display("FAIL single_count: got %0d expected 1", words); end
      if (level !== 4'd0) begin n_err++; $display("FAIL single_level: got %0d expected 0", level); end
      data_ready = 1'b0;
   endtask

   task automatic test_overflow();
      overflow_clr = 1'b1;
      step();
      overflow_clr = 1'b0;
      data_ready = 1'b0;
      for (int d = 1; d <= 9; d++) pulse(WIDTH'(d));
      repeat (3) step();
      n_cmp += 2;
      if (level !== 4'd8) begin n_err++; $display("FAIL ovf_level: got %0d expected 8", level); end
      if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %0b expected 1", overflow); end
`ifdef DATA_STAND_DROPCNT_EN
      n_cmp++;
      if (drop_count !== 16'd1) begin n_err++; $display("FAIL ovf_dropcnt: got %0d expected 1", drop_count); end
`endif
      data_ready = 1'b1;
      for (int d = 1; d <= 8; d++) begin
         n_cmp += 2;
         if (data_valid !== 1'b1) begin n_err++; $display("FAIL drain_valid: got %0b expected 1", data_valid); end
         if (data_stand !== WIDTH'(d)) begin n_err++; $display("FAIL drain_order: got %0h expected %0h", data_stand, d); end
         step();
      end
      n_cmp += 3;
      if (level !== 4'd0) begin n_err++; $display("FAIL drain_level: got %0d expected 0", level); end
      if (data_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty_valid: got %0b expected 0", data_valid); end
      if (data_stand !== '0) begin n_err++; $display("FAIL drain_empty_data: got %0h expected 0", data_stand); end
      data_ready = 1'b0;
      overflow_clr = 1'b1;
      step();
      overflow_clr = 1'b0;
      n_cmp++;
      if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %0b expected 0", overflow); end
   endtask

   task automatic test_full_pop_push();
      data_ready = 1'b0;
      for (int d = 0; d < DEPTH; d++) pulse(WIDTH'(14'h100 + d));
      data_rec = 14'h3FF;
      clock_recovery = 1'b1;
      step();
      step();
      clock_recovery = 1'b0;
      step();
      data_ready = 1'b1;
      step();
      data_ready = 1'b0;
      n_cmp += 3;
      if (level !== 4'd8) begin n_err++; $display("FAIL fullpp_level: got %0d expected 8", level); end
      if (overflow !== 1'b0) begin n_err++; $display("FAIL fullpp_overflow: got %0b expected 0", overflow); end
      if (data_stand !== 14'h101) begin n_err++; $display("FAIL fullpp_head: got %0h expected 101", data_stand); end
      data_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         n_cmp++;
         if (data_stand !== exp_head()) begin n_err++; $display("FAIL fullpp_drain: got %0h expected %0h", data_stand, exp_head()); end
         if (i == DEPTH - 1) begin
            n_cmp++;
            if (data_stand !== 14'h3FF) begin n_err++; $display("FAIL fullpp_last: got %0h expected 3ff", data_stand); end
         end
         step();
      end
      data_ready = 1'b0;
   endtask

   task automatic test_held_strobe();
      drain();
      data_rec = 14'h0C3;
      clock_recovery = 1'b1;
      repeat (20) step();
      clock_recovery = 1'b0;
      repeat (5) step();
      n_cmp += 2;
      if (level !== 4'd1) begin n_err++; $display("FAIL held_count: got %0d expected 1", level); end
      if (data_stand !== 14'h0C3) begin n_err++; $display("FAIL held_data: got %0h expected c3", data_stand); end
      clock_recovery = 1'b1; repeat (3) step();
      clock_recovery = 1'b0; step();
      clock_recovery = 1'b1; repeat (3) step();
      clock_recovery = 1'b0; repeat (5) step();
      n_cmp += 2;
      if (level !== exp_level()) begin n_err++; $display("FAIL gap_level: got %0d expected %0d", level, exp_level()); end
      if (level < 4'd2 || level > 4'd3) begin n_err++; $display("FAIL gap_range: got %0d expected 2..3", level); end
   endtask

   task automatic test_reset_mid();
      drain();
      for (int d = 0; d < 5; d++) pulse(WIDTH'(14'h200 + d));
      n_cmp++;
      if (level !== 4'd5) begin n_err++; $display("FAIL rmid_fill: got %0d expected 5", level); end
      data_rec = 14'h2AB;
      clock_recovery = 1'b1;
      reset = 1'b1;
      step();
      n_cmp += 3;
      if (level !== 4'd0) begin n_err++; $display("FAIL rmid_level: got %0d expected 0", level); end
      if (data_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %0b expected 0", data_valid); end
      if (data_stand !== '0) begin n_err++; $display("FAIL rmid_data: got %0h expected 0", data_stand); end
      step();
      reset = 1'b0;
      repeat (10) step();
      n_cmp += 2;
      if (level !== 4'd1) begin n_err++; $display("FAIL rmid_capture: got %0d expected 1", level); end
      if (data_stand !== 14'h2AB) begin n_err++; $display("FAIL rmid_word: got %0h expected 2ab", data_stand); end
      clock_recovery = 1'b0;
      repeat (3) step();
   endtask

   task automatic test_random();
      int left;
      left = 1;
      for (int c = 0; c < 1500; c++) begin
         left--;
         if (left <= 0) begin
            if (clock_recovery) begin
               clock_recovery = 1'b0;
               left = int'($urandom_range(1, 5));
            end else begin
               clock_recovery = 1'b1;
               data_rec = WIDTH'($urandom);
               left = int'($urandom_range(1, 4));
            end
         end
         if (c < 750) data_ready = ($urandom_range(0, 3) == 0);
         else data_ready = ($urandom_range(0, 3) != 0);
         overflow_clr = ($urandom_range(0, 31) == 0);
         step();
         n_cmp += 4;
         if (level !== exp_level()) begin n_err++; $display("FAIL rnd_level c=%0d: got %0d expected %0d", c, level, exp_level()); end
         if (data_valid !== (mq.size() != 0)) begin n_err++; $display("FAIL rnd_valid c=%0d: got %0b expected %0b", c, data_valid, mq.size() != 0); end
         if (data_stand !== exp_head()) begin n_err++; $display("FAIL rnd_data c=%0d: got %0h expected %0h", c, data_stand, exp_head()); end
         if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_overflow c=%0d: got %0b expected %0b", c, overflow, m_ovf); end
`ifdef DATA_STAND_DROPCNT_EN
         n_cmp++;
         if (drop_count !== 16'(m_cnt)) begin n_err++; $display("FAIL rnd_dropcnt c=%0d: got %0d expected %0d", c, drop_count, m_cnt); end
`endif
      end
      overflow_clr = 1'b0;
      data_ready = 1'b0;
      clock_recovery = 1'b0;
   endtask

   initial begin
      for (int i = 0; i <= SYNC + 1; i++) hist[i] = 1'b0;
      test_reset();
      test_single();
      test_overflow();
      test_full_pop_push();
      test_held_strobe();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
